// File: rtl/led_scanner_pkg.sv
// led_scanner_pkg: motion mode encodings shared by the LED scanner.
package led_scanner_pkg;
    typedef enum logic [1:0] {
        MODE_UP     = 2'd0,
        MODE_DOWN   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLANK  = 2'd3
    } mode_t;
endpackage

// File: rtl/step_prescaler.sv
// step_prescaler: registered step tick every step_div+1 enabled clocks.
module step_prescaler #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic [DIV_W-1:0] step_div,
    output logic             tick
);
    logic [DIV_W-1:0] cnt;
    logic             hit;
    assign hit = cnt >= step_div;
    // tick holds while disabled so a pending step survives a pause
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (enable) begin
            cnt  <= hit ? '0 : cnt + 1'b1;
            tick <= hit;
        end
    end
endmodule

// File: rtl/led_scanner.sv
// led_scanner: moving TRAIL-wide LED bar with sweep, bounce and blank modes.
module led_scanner
    import led_scanner_pkg::*;
#(
    parameter int N_LEDS = 8,
    parameter int TRAIL  = 2,
    parameter int DIV_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [DIV_W-1:0]  step_div,
    output logic [N_LEDS-1:0] led_out,
    output logic              cycle_done
);
    localparam int HW = $clog2(N_LEDS);
    localparam logic [HW-1:0] HMAX = HW'(N_LEDS - 1);
    mode_t             mode_q;
    logic [HW-1:0]     h, h_n, bcnt, bcnt_n;
    logic              dir, dir_n, blank, blank_n, wrap, tick, restart;
    logic [N_LEDS-1:0] bar;
    int                hi;
    assign restart = mode != mode_q;
    step_prescaler #(.DIV_W(DIV_W)) u_pre (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .clear    (restart),
        .step_div (step_div),
        .tick     (tick)
    );
    always_comb begin
        h_n     = h;
        dir_n   = dir;
        blank_n = blank;
        bcnt_n  = bcnt;
        wrap    = 1'b0;
        if (restart) begin
            h_n     = (mode == MODE_DOWN) ? HMAX : '0;
            dir_n   = mode == MODE_DOWN;
            blank_n = 1'b0;
            bcnt_n  = '0;
        end else if (enable && tick) begin
            case (mode_q)
                MODE_UP: begin
                    h_n  = (h == HMAX) ? '0 : h + 1'b1;
                    wrap = h == HMAX;
                end
                MODE_DOWN: begin
                    h_n  = (h == '0) ? HMAX : h - 1'b1;
                    wrap = h == '0;
                end
                MODE_BOUNCE: begin
                    h_n   = dir ? h - 1'b1 : h + 1'b1;
                    dir_n = dir ? (h != HW'(1)) : (h == HMAX - 1'b1);
                    wrap  = dir && (h == HW'(1));
                end
                MODE_BLANK: begin
                    if (blank) begin
                        bcnt_n  = (bcnt == HMAX) ? '0 : bcnt + 1'b1;
                        blank_n = bcnt != HMAX;
                        h_n     = (bcnt == HMAX) ? '0 : h;
                        wrap    = bcnt == HMAX;
                    end else begin
                        h_n     = (h == HMAX) ? h : h + 1'b1;
                        blank_n = h == HMAX;
                        bcnt_n  = '0;
                    end
                end
                default: ;
            endcase
        end
    end
    // bar is decoded from next state so led_out moves on the tick edge
    assign hi = int'(h_n);
    for (genvar i = 0; i < N_LEDS; i++) begin : g_bar
        assign bar[i] = !blank_n && (dir_n ? (i >= hi && i < hi + TRAIL)
                                           : (i <= hi && i > hi - TRAIL));
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= MODE_UP;
            h          <= '0;
            dir        <= 1'b0;
            blank      <= 1'b0;
            bcnt       <= '0;
            led_out    <= '0;
            cycle_done <= 1'b0;
        end else begin
            mode_q     <= mode_t'(mode);
            h          <= h_n;
            dir        <= dir_n;
            blank      <= blank_n;
            bcnt       <= bcnt_n;
            cycle_done <= wrap;
            if (restart || enable)
                led_out <= bar;
        end
    end
endmodule
